// File: rtl/conv_ctrl_pkg.sv
// Shared FSM state type and derived-size helpers for the shift-register
// convolution sequencer.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } ctrl_state_t;

    function automatic int unsigned result_dim(input int unsigned img,
                                               input int unsigned fl,
                                               input int unsigned stride);
        return (img - fl) / stride + 1;
    endfunction

    function automatic int unsigned w_scan(input int unsigned img_w,
                                           input int unsigned fl,
                                           input int unsigned stride_w);
        return (result_dim(img_w, fl, stride_w) - 1) * stride_w + fl;
    endfunction

    function automatic int unsigned bank_aw(input int unsigned img_w,
                                            input int unsigned img_h,
                                            input int unsigned fl);
        return $clog2(((img_h + fl - 1) / fl) * img_w);
    endfunction

    function automatic int unsigned res_aw(input int unsigned rw,
                                           input int unsigned rh);
        return $clog2(rw * rh);
    endfunction

endpackage

// File: rtl/conv_ctrl_delay_pipe.sv
// Fixed-depth register pipe aligning datapath control with BRAM read data.
module conv_ctrl_delay_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_bram_sr_fast_ctrl.sv
// Sequencer for the shift-register convolution datapath: walks image columns
// over FILTER_L striped banks and drives read-aligned datapath controls.
module conv_bram_sr_fast_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W    = 16,
    parameter int unsigned IMG_H    = 16,
    parameter int unsigned FILTER_L = 3,
    parameter int unsigned STRIDE_W = 1,
    parameter int unsigned STRIDE_H = 1,
    parameter int unsigned RD_LAT   = 1,
    localparam int unsigned RESULT_W = result_dim(IMG_W, FILTER_L, STRIDE_W),
    localparam int unsigned RESULT_H = result_dim(IMG_H, FILTER_L, STRIDE_H),
    localparam int unsigned W_SCAN   = w_scan(IMG_W, FILTER_L, STRIDE_W),
    localparam int unsigned BANK_AW  = bank_aw(IMG_W, IMG_H, FILTER_L),
    localparam int unsigned FL_AW    = $clog2(FILTER_L),
    localparam int unsigned RES_AW   = res_aw(RESULT_W, RESULT_H)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [FILTER_L*BANK_AW-1:0] img_rdaddr,
    output logic                        img_rden,
    output logic                        dpath_wren,
    output logic                        dpath_sum_en,
    output logic [FL_AW-1:0]            dpath_rotation_offset,
    output logic [RES_AW-1:0]           dpath_result_wraddr,
    input  logic                        last_val
);

    localparam int unsigned R_W    = $clog2(RESULT_H + 1);
    localparam int unsigned C_W    = $clog2(W_SCAN + 1);
    localparam int unsigned PH_W   = $clog2(STRIDE_W + 1);
    localparam int unsigned TS_W   = FL_AW + 1;
    localparam int unsigned PIPE_W = 1 + FL_AW + RES_AW;

    ctrl_state_t state, state_nxt;

    logic [R_W-1:0]     row;
    logic [C_W-1:0]     col;
    logic [PH_W-1:0]    phase;
    logic [FL_AW-1:0]   top;
    logic [RES_AW-1:0]  tag;
    logic [BANK_AW-1:0] base [FILTER_L];
    logic               last_seen;

    logic               scan;
    logic               col_end;
    logic               row_last;
    logic [TS_W-1:0]    top_sum;
    logic [TS_W-1:0]    top_wrap;
    logic [FILTER_L-1:0] bump;
    logic [PIPE_W-1:0]  pipe_in;
    logic [PIPE_W-1:0]  pipe_out;

    assign scan     = (state == SCAN);
    assign col_end  = (col == C_W'(W_SCAN - 1));
    assign row_last = (row == R_W'(RESULT_H - 1));
    assign top_sum  = {1'b0, top} + TS_W'(STRIDE_H);
    assign top_wrap = (top_sum >= TS_W'(FILTER_L)) ? top_sum - TS_W'(FILTER_L) : top_sum;

    // A bank advances to its next row group when its window slot (distance
    // from the top bank) falls among the STRIDE_H rows that drop out.
    always_comb begin
        bump = '0;
        for (int unsigned b = 0; b < FILTER_L; b++) begin
            if (b >= 32'(top)) bump[b] = (b - 32'(top)) < STRIDE_H;
            else               bump[b] = (b + FILTER_L - 32'(top)) < STRIDE_H;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        img_rden  = scan;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (col_end && row_last) state_nxt = DRAIN;
            DRAIN:   if (last_val || last_seen) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        img_rdaddr = '0;
        if (scan) begin
            for (int unsigned b = 0; b < FILTER_L; b++)
                img_rdaddr[b*BANK_AW +: BANK_AW] = base[b] + BANK_AW'(col);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            phase     <= '0;
            top       <= '0;
            tag       <= '0;
            last_seen <= 1'b0;
            for (int unsigned b = 0; b < FILTER_L; b++) base[b] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                row   <= '0;
                col   <= '0;
                phase <= '0;
                top   <= '0;
                tag   <= '0;
                for (int unsigned b = 0; b < FILTER_L; b++) base[b] <= '0;
            end else if (scan) begin
                if (col_end) begin
                    // Final column of the final row leaves counters untouched
                    // so none of them ever wraps.
                    if (!row_last) begin
                        col   <= '0;
                        phase <= '0;
                        row   <= row + R_W'(1);
                        top   <= top_wrap[FL_AW-1:0];
                        tag   <= tag + RES_AW'(1);
                        for (int unsigned b = 0; b < FILTER_L; b++)
                            if (bump[b]) base[b] <= base[b] + BANK_AW'(IMG_W);
                    end
                end else begin
                    col <= col + C_W'(1);
                    if (col >= C_W'(FILTER_L - 1)) begin
                        if (phase == '0) tag <= tag + RES_AW'(1);
                        phase <= (phase == PH_W'(STRIDE_W - 1)) ? '0 : phase + PH_W'(1);
                    end
                end
            end

            if (state == IDLE)  last_seen <= 1'b0;
            else if (last_val)  last_seen <= 1'b1;
        end
    end

    assign pipe_in = scan ? {1'b1, top, tag} : '0;

    conv_ctrl_delay_pipe #(
        .WIDTH (PIPE_W),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign {dpath_wren, dpath_rotation_offset, dpath_result_wraddr} = pipe_out;
    assign dpath_sum_en = dpath_wren;

    param_ok: assert property (@(posedge clk)
        (STRIDE_W <= FILTER_L) && (STRIDE_H <= FILTER_L) && (RESULT_W >= 2));

endmodule

// File: tb/tb_conv_bram_sr_fast_ctrl.sv
// Scoreboard bench: three sequencer configurations checked against expected
// read-address and result-tag queues plus a small last_val datapath model.
module tb_conv_bram_sr_fast_ctrl;

    typedef logic [2:0][31:0] rd_t;
    typedef struct packed { int tag; int rot; } wr_t;

    logic clk = 1'b0;
    logic rst, a_rst;
    logic a_start, b_start, c_start;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: defaults, B: IMG_W=9 STRIDE_W=2, C: RD_LAT=2
    logic        a_busy, a_done, a_rden, a_wren, a_sum, a_lv;
    logic [20:0] a_addr;
    logic [1:0]  a_rot;
    logic [7:0]  a_tag;
    logic        b_busy, b_done, b_rden, b_wren, b_sum, b_lv;
    logic [17:0] b_addr;
    logic [1:0]  b_rot;
    logic [5:0]  b_tag;
    logic        c_busy, c_done, c_rden, c_wren, c_sum, c_lv;
    logic [20:0] c_addr;
    logic [1:0]  c_rot;
    logic [7:0]  c_tag;

    conv_bram_sr_fast_ctrl u_a (
        .clk(clk), .reset(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
        .img_rdaddr(a_addr), .img_rden(a_rden), .dpath_wren(a_wren), .dpath_sum_en(a_sum),
        .dpath_rotation_offset(a_rot), .dpath_result_wraddr(a_tag), .last_val(a_lv));

    conv_bram_sr_fast_ctrl #(.IMG_W(9), .STRIDE_W(2)) u_b (
        .clk(clk), .reset(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .img_rdaddr(b_addr), .img_rden(b_rden), .dpath_wren(b_wren), .dpath_sum_en(b_sum),
        .dpath_rotation_offset(b_rot), .dpath_result_wraddr(b_tag), .last_val(b_lv));

    conv_bram_sr_fast_ctrl #(.RD_LAT(2)) u_c (
        .clk(clk), .reset(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .img_rdaddr(c_addr), .img_rden(c_rden), .dpath_wren(c_wren), .dpath_sum_en(c_sum),
        .dpath_rotation_offset(c_rot), .dpath_result_wraddr(c_tag), .last_val(c_lv));

    // Datapath model: flags the final result address 4 cycles after its wren.
    logic [3:0] a_pipe = '0, b_pipe = '0, c_pipe = '0;
    always @(posedge clk) begin
        a_pipe <= a_rst ? 4'b0 : {a_pipe[2:0], a_wren && (a_tag == 8'd195)};
        b_pipe <= rst   ? 4'b0 : {b_pipe[2:0], b_wren && (b_tag == 6'd55)};
        c_pipe <= rst   ? 4'b0 : {c_pipe[2:0], c_wren && (c_tag == 8'd195)};
    end
    assign a_lv = a_pipe[3];
    assign b_lv = b_pipe[3];
    assign c_lv = c_pipe[3];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    rd_t tmp_rd[$], def_rd[$], bref_rd[$], qa_rd[$], qb_rd[$], qc_rd[$];
    wr_t tmp_wr[$], def_wr[$], bref_wr[$], qa_wr[$], qb_wr[$], qc_wr[$];

    // Expected reads/tags straight from the row-striping and tag formulas
    // (IMG_H=16, FILTER_L=3, STRIDE_H=1).
    function automatic void gen(input int iw, input int sw);
        int rw, ws, h, d, k;
        rd_t e;
        wr_t x;
        tmp_rd.delete();
        tmp_wr.delete();
        rw = (iw - 3) / sw + 1;
        ws = (rw - 1) * sw + 3;
        for (int r = 0; r < 14; r++) begin
            for (int w = 0; w < ws; w++) begin
                for (int j = 0; j < 3; j++) begin
                    h = r + j;
                    e[h % 3] = 32'((h / 3) * iw + w);
                end
                d = w - 2;
                k = (d <= 0) ? 0 : (d + sw - 1) / sw;
                x.tag = r * rw + k;
                x.rot = r % 3;
                tmp_rd.push_back(e);
                tmp_wr.push_back(x);
            end
        end
    endfunction

    int   a_nrd, a_nwr, a_ndone, a_last_rd;
    int   b_nrd, b_nwr, b_ndone;
    int   c_nrd, c_ndone, c_last_rd;
    logic a_h1 = 1'b0, b_h1 = 1'b0, c_h1 = 1'b0, c_h2 = 1'b0;
    int   b_row0 [9] = '{0, 0, 0, 1, 1, 2, 2, 3, 3};

    always @(negedge clk) begin : mon_a
        rd_t e;
        wr_t x;
        if (a_rden) begin
            if (qa_rd.size() == 0) chk("a_rd_unexpected", 1, 0);
            else begin
                e = qa_rd.pop_front();
                chk("a_addr_b0", 32'(a_addr[6:0]), e[0]);
                chk("a_addr_b1", 32'(a_addr[13:7]), e[1]);
                chk("a_addr_b2", 32'(a_addr[20:14]), e[2]);
                if (qa_rd.size() == 0) a_last_rd = cyc;
            end
            if (a_nrd == 21) begin
                chk("a_r1w5_b0", 32'(a_addr[6:0]), 21);
                chk("a_r1w5_b1", 32'(a_addr[13:7]), 5);
                chk("a_r1w5_b2", 32'(a_addr[20:14]), 5);
            end
            a_nrd++;
        end
        if (a_wren) begin
            if (qa_wr.size() == 0) chk("a_wr_unexpected", 1, 0);
            else begin
                x = qa_wr.pop_front();
                chk("a_tag", 32'(a_tag), x.tag);
                chk("a_rot", 32'(a_rot), x.rot);
            end
            if (a_nwr < 16) chk("a_row0_tag", 32'(a_tag), (a_nwr < 3) ? 0 : a_nwr - 2);
            if (a_nwr == 16) begin
                chk("a_row1_tag", 32'(a_tag), 14);
                chk("a_row1_rot", 32'(a_rot), 1);
            end
            if (a_nwr == 48) chk("a_row3_rot", 32'(a_rot), 0);
            a_nwr++;
        end
        chk("a_wren_lag", 32'(a_wren), 32'(a_h1));
        chk("a_sum_en", 32'(a_sum), 32'(a_wren));
        a_h1 = a_rst ? 1'b0 : a_rden;
        if (a_done) begin
            a_ndone++;
            chk("a_done_latency", cyc - a_last_rd, 6);
        end
    end

    always @(negedge clk) begin : mon_b
        rd_t e;
        wr_t x;
        if (b_rden) begin
            if (qb_rd.size() == 0) chk("b_rd_unexpected", 1, 0);
            else begin
                e = qb_rd.pop_front();
                chk("b_addr_b0", 32'(b_addr[5:0]), e[0]);
                chk("b_addr_b1", 32'(b_addr[11:6]), e[1]);
                chk("b_addr_b2", 32'(b_addr[17:12]), e[2]);
            end
            if (b_nrd == 9) chk("b_r1w0_b0", 32'(b_addr[5:0]), 9);
            b_nrd++;
        end
        if (b_wren) begin
            if (qb_wr.size() == 0) chk("b_wr_unexpected", 1, 0);
            else begin
                x = qb_wr.pop_front();
                chk("b_tag", 32'(b_tag), x.tag);
                chk("b_rot", 32'(b_rot), x.rot);
            end
            if (b_nwr < 9) chk("b_row0_tag", 32'(b_tag), b_row0[b_nwr]);
            b_nwr++;
        end
        chk("b_wren_lag", 32'(b_wren), 32'(b_h1));
        b_h1 = rst ? 1'b0 : b_rden;
        if (b_done) b_ndone++;
    end

    always @(negedge clk) begin : mon_c
        rd_t e;
        wr_t x;
        if (c_rden) begin
            if (qc_rd.size() == 0) chk("c_rd_unexpected", 1, 0);
            else begin
                e = qc_rd.pop_front();
                chk("c_addr_b0", 32'(c_addr[6:0]), e[0]);
                chk("c_addr_b1", 32'(c_addr[13:7]), e[1]);
                chk("c_addr_b2", 32'(c_addr[20:14]), e[2]);
                if (qc_rd.size() == 0) c_last_rd = cyc;
            end
            c_nrd++;
        end
        if (c_wren) begin
            if (qc_wr.size() == 0) chk("c_wr_unexpected", 1, 0);
            else begin
                x = qc_wr.pop_front();
                chk("c_tag", 32'(c_tag), x.tag);
                chk("c_rot", 32'(c_rot), x.rot);
            end
        end
        chk("c_wren_lag2", 32'(c_wren), 32'(c_h2));
        c_h2 = rst ? 1'b0 : c_h1;
        c_h1 = rst ? 1'b0 : c_rden;
        if (c_done) begin
            c_ndone++;
            chk("c_done_latency", cyc - c_last_rd, 7);
        end
    end

    initial begin
        rst = 1'b1; a_rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_nrd = 0; a_nwr = 0; a_ndone = 0; a_last_rd = 0;
        b_nrd = 0; b_nwr = 0; b_ndone = 0;
        c_nrd = 0; c_ndone = 0; c_last_rd = 0;
        gen(16, 1); def_rd = tmp_rd; def_wr = tmp_wr;
        gen(9, 2);  bref_rd = tmp_rd; bref_wr = tmp_wr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_rden", 32'(a_rden), 0);
        chk("rst_wren", 32'(a_wren), 0);
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_rot", 32'(a_rot), 0);
        chk("rst_tag", 32'(a_tag), 0);
        @(posedge clk); #1 rst = 1'b0; a_rst = 1'b0;

        fork
            begin : seq_a
                qa_rd = def_rd; qa_wr = def_wr;
                @(posedge clk); #1 a_start = 1'b1; @(posedge clk); #1 a_start = 1'b0;
                repeat (50) @(posedge clk);
                @(negedge clk); chk("a_busy_mid", 32'(a_busy), 1);
                @(posedge clk); #1 a_start = 1'b1; @(posedge clk); #1 a_start = 1'b0;
                for (int i = 0; i < 1000 && a_ndone == 0; i++) @(posedge clk);
                @(negedge clk);
                chk("a_busy_after_done", 32'(a_busy), 0);
                chk("a_done_single", 32'(a_done), 0);
                repeat (10) @(posedge clk);
                chk("a_done_count", a_ndone, 1);
                chk("a_read_count", a_nrd, 224);
                chk("a_rd_left", qa_rd.size(), 0);
                chk("a_wr_left", qa_wr.size(), 0);

                qa_rd = def_rd; qa_wr = def_wr;
                a_nrd = 0; a_nwr = 0; a_ndone = 0;
                @(posedge clk); #1 a_start = 1'b1; @(posedge clk); #1 a_start = 1'b0;
                for (int i = 0; i < 500 && a_nrd < 115; i++) @(posedge clk);
                chk("a_reached_row7", 32'(a_nrd >= 115), 1);
                #1 a_rst = 1'b1; @(posedge clk); #1 a_rst = 1'b0;
                @(negedge clk);
                chk("abort_busy", 32'(a_busy), 0);
                chk("abort_rden", 32'(a_rden), 0);
                chk("abort_wren", 32'(a_wren), 0);
                chk("abort_addr", 32'(a_addr), 0);
                chk("abort_rot", 32'(a_rot), 0);
                chk("abort_tag", 32'(a_tag), 0);
                qa_rd.delete(); qa_wr.delete();
                repeat (20) @(posedge clk);
                chk("abort_no_done", a_ndone, 0);

                qa_rd = def_rd; qa_wr = def_wr;
                a_nrd = 0; a_nwr = 0; a_ndone = 0;
                @(posedge clk); #1 a_start = 1'b1; @(posedge clk); #1 a_start = 1'b0;
                for (int i = 0; i < 1000 && a_ndone == 0; i++) @(posedge clk);
                repeat (10) @(posedge clk);
                chk("a_rerun_done_count", a_ndone, 1);
                chk("a_rerun_read_count", a_nrd, 224);
                chk("a_rerun_rd_left", qa_rd.size(), 0);
            end
            begin : seq_b
                qb_rd = bref_rd; qb_wr = bref_wr;
                @(posedge clk); #1 b_start = 1'b1; @(posedge clk); #1 b_start = 1'b0;
                for (int i = 0; i < 1000 && b_ndone == 0; i++) @(posedge clk);
                repeat (10) @(posedge clk);
                chk("b_done_count", b_ndone, 1);
                chk("b_read_count", b_nrd, 126);
                chk("b_rd_left", qb_rd.size(), 0);
                chk("b_wr_left", qb_wr.size(), 0);
            end
            begin : seq_c
                qc_rd = def_rd; qc_wr = def_wr;
                @(posedge clk); #1 c_start = 1'b1; @(posedge clk); #1 c_start = 1'b0;
                for (int i = 0; i < 1000 && c_ndone == 0; i++) @(posedge clk);
                repeat (10) @(posedge clk);
                chk("c_done_count", c_ndone, 1);
                chk("c_read_count", c_nrd, 224);
                chk("c_rd_left", qc_rd.size(), 0);
                chk("c_wr_left", qc_wr.size(), 0);
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
